jtag_dmi_initiator: RTL and testbench
=====================================

# jtag_dmi_initiator

DTM-side initiator for the debug module interface (DMI). Accepts a decoded DMI command (address, data, op) from the JTAG TAP/DTM shift logic, already in the `clk` domain. Issues the command to the debug module as a single-cycle request and tracks the DM's `dm_is_busy` handshake. Captures the 40-bit response and keeps the sticky `dmistat` status the TAP reports in the DTMCS register.

## Interface
Parameters:
- `DMI_ADDR_BITS`, 6, DMI address width
- `DMI_DATA_BITS`, 32, DMI data width
- `DMI_OP_BITS`, 2, op/status field width
- `DTM_REQ_BITS`, `DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS` (40), request/response width, packed `{addr, data, op}`
- `TIMEOUT_CYCLES`, 255, maximum cycles spent waiting on the DM (1..255)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  command from DTM shift logic
- `cmd_ready`  out  1  initiator can accept a command
- `cmd_data`  in  40  `{addr, data, op}`; op 00 NOP, 01 READ, 10 WRITE
- `dmi_reset`  in  1  single-cycle pulse that clears sticky `dmi_stat`
- `dtm_req_valid`  out  1  single-cycle request pulse to the DM
- `dtm_req_data`  out  40  request word, held stable from issue until return to IDLE
- `dm_is_busy`  in  1  DM busy flag
- `dm_resp_data`  in  40  DM response word
- `rsp_valid`  out  1  single-cycle pulse: `rsp_data` updated
- `rsp_data`  out  40  last captured response
- `dmi_busy`  out  1  transaction outstanding (state != IDLE)
- `dmi_stat`  out  2  sticky status: 0 ok, 2 failed (timeout), 3 busy overrun

## Operation
- FSM states: IDLE, REQ, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE: `cmd_ready`=1.
  - On `cmd_valid` with `dmi_stat`==0: latch `cmd_data` into `dtm_req_data`, go to REQ.
  - On `cmd_valid` with `dmi_stat`!=0: the command is consumed and dropped; stay IDLE.
- REQ: `dtm_req_valid`=1 for exactly this cycle; go to WAIT_BUSY. The request is never held for two cycles, because the DM re-accepts a request while idle.
- WAIT_BUSY: on `dm_is_busy`=1, go to WAIT_DONE.
- WAIT_DONE: on `dm_is_busy`=0, capture `dm_resp_data` into `rsp_data` and go to RESP.
- RESP: `rsp_valid`=1 for one cycle; go to IDLE.
- All ops, including NOP, are forwarded unchanged. The op field of `rsp_data` is passed through from the DM.
- Timeout:
  - An 8-bit counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY and WAIT_DONE.
  - On reaching `TIMEOUT_CYCLES`: set `dmi_stat`=2, load `rsp_data`={latched addr, 32'h0, 2'b10}, go to RESP.
- Overrun:
  - `cmd_valid`=1 in any state other than IDLE sets `dmi_stat`=3; the command is dropped.
  - The outstanding transaction still completes normally.
- Status precedence:
  - `dmi_stat` is never overwritten by a non-zero value once non-zero (first error sticks).
  - `dmi_reset` clears it to 0 in any state and does not abort an outstanding transaction.
  - `dmi_reset` wins over a simultaneous overrun or timeout.
- Reset mid-transaction: `rst` forces IDLE immediately. A later DM busy/response is ignored because IDLE does not watch `dm_is_busy`.

## Timing
- Reset values:
  - state IDLE, `dtm_req_valid` 0, `rsp_valid` 0, `dmi_stat` 0, `dmi_busy` 0.
  - `cmd_ready` 1 in the cycle after reset.
  - `dtm_req_data` and `rsp_data` 40'h0, counter 0.
- All outputs are registered or decoded from the registered state only; no combinational input-to-output path.
- Nominal latency, with the command accepted at edge T:
  - `dtm_req_valid` high in cycle T+1.
  - DM `dm_is_busy` high in T+2, low with response in T+3.
  - `rsp_valid` high in T+4; back to IDLE with `cmd_ready`=1 in T+5.
- Back-to-back commands: minimum spacing is 5 cycles.
- Timeout fires `TIMEOUT_CYCLES` cycles after entry to WAIT_BUSY when the DM never responds.

## Structure
- Shared debug package holds:
  - the DMI width constants;
  - op encodings `DTM_OP_NOP/READ/WRITE`;
  - status codes `DMI_STAT_OK=0`, `DMI_STAT_FAILED=2`, `DMI_STAT_BUSY=3`;
  - the FSM state encoding.
- Single module with no sub-module; the timeout counter is inline.

## Test plan
- READ DMSTATUS: `cmd_data`={6'h11, 32'h0, 2'b01}; DM model busy one cycle and returns {6'h11, 32'h400982, 2'b00} -> `dtm_req_valid` is a single pulse at T+1, `rsp_valid` at T+4, `rsp_data`=={6'h11, 32'h400982, 2'b00}, `dmi_stat`==0.
- WRITE DATA0: `cmd_data`={6'h04, 32'hDEADBEEF, 2'b10} -> `dtm_req_data` carries the same value for the whole transaction; response op 00; `dmi_busy` high T+1..T+4.
- Overrun: second `cmd_valid` at T+2 -> `dmi_stat`=3, first transaction completes, exactly one `dtm_req_valid` pulse. The next command is dropped until a `dmi_reset` pulse, after which a new command is issued normally.
- Timeout: DM model never asserts busy, `TIMEOUT_CYCLES`=8 -> `rsp_valid` 9 cycles after `dtm_req_valid`, `rsp_data` op=2'b10, `dmi_stat`=2.
- `rst` asserted in WAIT_DONE, then DM response arrives -> no `rsp_valid`, all outputs at reset values, `cmd_ready`=1 the cycle after `rst` drops.
- `dmi_reset` coincident with an overrun `cmd_valid` -> `dmi_stat` stays 0.

Source files
------------

// File: rtl/jtag_dmi_initiator_pkg.sv
// Shared debug definitions for the DTM-side DMI initiator.
//   - DMI field widths and the packed {addr, data, op} request width
//   - DMI op encodings carried in the low field of a request
//   - sticky dmistat codes reported to the TAP through DTMCS
//   - initiator FSM state encoding
package jtag_dmi_initiator_pkg;

  localparam int DMI_ADDR_BITS = 6;
  localparam int DMI_DATA_BITS = 32;
  localparam int DMI_OP_BITS   = 2;
  localparam int DTM_REQ_BITS  = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;

  localparam logic [1:0] DTM_OP_NOP   = 2'b00;
  localparam logic [1:0] DTM_OP_READ  = 2'b01;
  localparam logic [1:0] DTM_OP_WRITE = 2'b10;

  localparam logic [1:0] DMI_STAT_OK     = 2'd0;
  localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
  localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } dmi_state_e;

endpackage : jtag_dmi_initiator_pkg

// File: rtl/jtag_dmi_initiator.sv
// DTM-side initiator for the debug module interface.
// Takes one decoded {addr, data, op} command from the TAP shift logic,
// issues it to the DM as a one-cycle request, follows the DM busy
// handshake, captures the response and maintains the sticky dmistat.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   cmd_valid/ready command handshake from the DTM shift logic
//   cmd_data        {addr, data, op}
//   dmi_reset       one-cycle pulse clearing dmi_stat
//   dtm_req_valid   one-cycle request pulse to the DM
//   dtm_req_data    request word, stable for the whole transaction
//   dm_is_busy      DM busy flag
//   dm_resp_data    DM response word
//   rsp_valid       one-cycle pulse when rsp_data is updated
//   rsp_data        last captured (or timeout-synthesised) response
//   dmi_busy        transaction outstanding
//   dmi_stat        sticky status: 0 ok, 2 failed, 3 busy overrun
module jtag_dmi_initiator
  import jtag_dmi_initiator_pkg::*;
#(
  parameter int DMI_ADDR_BITS  = jtag_dmi_initiator_pkg::DMI_ADDR_BITS,
  parameter int DMI_DATA_BITS  = jtag_dmi_initiator_pkg::DMI_DATA_BITS,
  parameter int DMI_OP_BITS    = jtag_dmi_initiator_pkg::DMI_OP_BITS,
  parameter int DTM_REQ_BITS   = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DTM_REQ_BITS-1:0] cmd_data,
  input  logic                    dmi_reset,
  output logic                    dtm_req_valid,
  output logic [DTM_REQ_BITS-1:0] dtm_req_data,
  input  logic                    dm_is_busy,
  input  logic [DTM_REQ_BITS-1:0] dm_resp_data,
  output logic                    rsp_valid,
  output logic [DTM_REQ_BITS-1:0] rsp_data,
  output logic                    dmi_busy,
  output logic [DMI_OP_BITS-1:0]  dmi_stat
);

  // Counter value in the last cycle of the waiting budget: the counter is
  // 0 in the first WAIT_BUSY cycle, so the timeout decision is taken in the
  // TIMEOUT_CYCLES-th waiting cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [DMI_OP_BITS-1:0] STAT_OK     = DMI_OP_BITS'(DMI_STAT_OK);
  localparam logic [DMI_OP_BITS-1:0] STAT_FAILED = DMI_OP_BITS'(DMI_STAT_FAILED);
  localparam logic [DMI_OP_BITS-1:0] STAT_BUSY   = DMI_OP_BITS'(DMI_STAT_BUSY);

  dmi_state_e                state_q, state_d;
  logic [DTM_REQ_BITS-1:0]   req_data_q, req_data_d;
  logic [DTM_REQ_BITS-1:0]   rsp_data_q, rsp_data_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [DMI_OP_BITS-1:0]    stat_q, stat_d;
  logic                      timeout;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    req_data_d = req_data_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    stat_d     = stat_q;
    timeout    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // With an error pending the command is consumed but never issued.
        if (cmd_valid && (stat_q == STAT_OK)) begin
          req_data_d = cmd_data;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
        end else if (dm_is_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving in the last budget cycle still completes.
        if (!dm_is_busy) begin
          rsp_data_d = dm_resp_data;
          state_d    = ST_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A timed-out transaction reports the latched address with a failed op.
    if (timeout) begin
      rsp_data_d = {req_data_q[DTM_REQ_BITS-1 -: DMI_ADDR_BITS],
                    {DMI_DATA_BITS{1'b0}}, STAT_FAILED};
      state_d    = ST_RESP;
    end

    // First error sticks; dmi_reset beats any error raised in the same cycle.
    if (dmi_reset) begin
      stat_d = STAT_OK;
    end else if (stat_q == STAT_OK) begin
      if (cmd_valid && (state_q != ST_IDLE)) begin
        stat_d = STAT_BUSY;
      end else if (timeout) begin
        stat_d = STAT_FAILED;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the reset is synchronous, so it lives inside the
  // clocked block and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_data_q <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      stat_q     <= STAT_OK;
    end else begin
      state_q    <= state_d;
      req_data_q <= req_data_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      stat_q     <= stat_d;
    end
  end

  // Every output is a flop or a decode of the registered state.
  assign cmd_ready     = (state_q == ST_IDLE);
  assign dtm_req_valid = (state_q == ST_REQ);
  assign rsp_valid     = (state_q == ST_RESP);
  assign dmi_busy      = (state_q != ST_IDLE);
  assign dtm_req_data  = req_data_q;
  assign rsp_data      = rsp_data_q;
  assign dmi_stat      = stat_q;

endmodule : jtag_dmi_initiator

// File: tb/tb_jtag_dmi_initiator.sv
// Self-checking bench for jtag_dmi_initiator. Inputs are driven and outputs
// sampled on the falling edge. Cycle 0 of a transaction is the cycle the
// command is presented; the request is expected in cycle 1. The DM is
// modelled inline: busy from cycle 1+a for b cycles, response valid after.
module tb_jtag_dmi_initiator;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [39:0] cmd_data;
  logic        dmi_reset;
  logic        dtm_req_valid;
  logic [39:0] dtm_req_data;
  logic        dm_is_busy;
  logic [39:0] dm_resp_data;
  logic        rsp_valid;
  logic [39:0] rsp_data;
  logic        dmi_busy;
  logic [1:0]  dmi_stat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jtag_dmi_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .dmi_reset    (dmi_reset),
    .dtm_req_valid(dtm_req_valid),
    .dtm_req_data (dtm_req_data),
    .dm_is_busy   (dm_is_busy),
    .dm_resp_data (dm_resp_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .dmi_busy     (dmi_busy),
    .dmi_stat     (dmi_stat)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: transaction outcome from the DM's timing alone.
  // The DM finishes in time when it drops busy before the waiting budget
  // (TO cycles starting at cycle 2) runs out; otherwise the initiator gives
  // up in cycle 1+TO and responds one cycle later.
  function automatic void predict(input logic [39:0] cmd, input int a, input int b,
                                  input logic [39:0] resp, input int ovr_at,
                                  input int dr_at, input logic [1:0] s_in,
                                  output int rc, output logic [39:0] rsp,
                                  output logic [1:0] s_out);
    bit in_time = (a + b) < TO;
    int to_cyc  = in_time ? -1 : 1 + TO;
    logic [1:0] s = s_in;
    rc  = in_time ? a + b + 2 : TO + 2;
    rsp = in_time ? resp : {cmd[39:34], 32'h0, 2'b10};
    for (int c = 1; c <= rc; c++) begin
      if (c == dr_at)                 s = 2'd0;
      else if (s == 0 && c == ovr_at) s = 2'd3;
      else if (s == 0 && c == to_cyc) s = 2'd2;
    end
    s_out = s;
  endfunction

  // One full transaction; expects the initiator idle with dmi_stat==0.
  task automatic run_txn(input string tag, input logic [39:0] cmd, input int a,
                         input int b, input logic [39:0] resp, input int ovr_at,
                         input int dr_at, input int exp_rc,
                         input logic [39:0] exp_rsp, input logic [1:0] exp_stat);
    int req_cnt = 0, req_cyc = -1, rsp_cnt = 0, rsp_cyc = -1;
    logic [39:0] rsp_seen = '0;
    bit busy_ok = 1, hold_ok = 1, ready_ok = 1;
    cmd_valid    = 1'b1;
    cmd_data     = cmd;
    dm_is_busy   = 1'b0;
    dm_resp_data = ~resp;
    for (int n = 1; n <= exp_rc + 2; n++) begin
      @(negedge clk);
      cmd_valid    = (n == ovr_at);
      cmd_data     = (n == ovr_at) ? ~cmd : cmd;
      dmi_reset    = (n == dr_at);
      dm_is_busy   = (n >= 1 + a) && (n < 1 + a + b);
      dm_resp_data = (n >= 1 + a + b) ? resp : ~resp;
      if (dtm_req_valid) begin req_cnt++; req_cyc = n; end
      if (rsp_valid) begin rsp_cnt++; rsp_cyc = n; rsp_seen = rsp_data; end
      if (dmi_busy !== (n <= exp_rc)) busy_ok = 0;
      if (cmd_ready !== (n > exp_rc)) ready_ok = 0;
      if (n <= exp_rc && dtm_req_data !== cmd) hold_ok = 0;
    end
    check({tag, " req_pulses"}, req_cnt, 1);
    check({tag, " req_cycle"}, req_cyc, 1);
    check({tag, " rsp_pulses"}, rsp_cnt, 1);
    check({tag, " rsp_cycle"}, rsp_cyc, exp_rc);
    check({tag, " rsp_data"}, rsp_seen, exp_rsp);
    check({tag, " rsp_data_held"}, rsp_data, exp_rsp);
    check({tag, " dmi_busy_window"}, busy_ok, 1);
    check({tag, " cmd_ready_window"}, ready_ok, 1);
    check({tag, " req_data_stable"}, hold_ok, 1);
    check({tag, " dmi_stat"}, dmi_stat, exp_stat);
    dm_is_busy = 1'b0;
    dmi_reset  = 1'b0;
  endtask

  // Command while an error is pending: must be consumed and not issued.
  task automatic drop_cmd(input string tag, input logic [39:0] cmd, input logic [1:0] s);
    int req_cnt = 0;
    bit busy_seen = 0;
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (dtm_req_valid) req_cnt++;
      if (dmi_busy) busy_seen = 1;
    end
    check({tag, " drop_no_req"}, req_cnt, 0);
    check({tag, " drop_not_busy"}, busy_seen, 0);
    check({tag, " drop_stat_kept"}, dmi_stat, s);
  endtask

  task automatic pulse_dmi_reset(input string tag);
    dmi_reset = 1'b1;
    @(negedge clk);
    dmi_reset = 1'b0;
    check({tag, " stat_cleared"}, dmi_stat, 0);
  endtask

  typedef struct {
    string       name;
    logic [39:0] cmd;
    int          a;
    int          b;
    logic [39:0] resp;
    int          ovr_at;
    int          dr_at;
    int          exp_rc;
    logic [39:0] exp_rsp;
    logic [1:0]  exp_stat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  s_model;
    logic [39:0] cmd, resp, exp_rsp;
    int          a, b, rc, ovr_at, dr_at, mode;

    vecs[0] = '{"read_dmstatus", {6'h11, 32'h0, 2'b01}, 1, 1,
                {6'h11, 32'h400982, 2'b00}, 0, 0, 4, {6'h11, 32'h400982, 2'b00}, 2'd0};
    vecs[1] = '{"write_data0", {6'h04, 32'hDEADBEEF, 2'b10}, 1, 1,
                {6'h04, 32'h0, 2'b00}, 0, 0, 4, {6'h04, 32'h0, 2'b00}, 2'd0};
    vecs[2] = '{"nop_passthru", {6'h3F, 32'h12345678, 2'b00}, 2, 3,
                {6'h3F, 32'hCAFEF00D, 2'b11}, 0, 0, 7, {6'h3F, 32'hCAFEF00D, 2'b11}, 2'd0};
    vecs[3] = '{"timeout_no_busy", {6'h10, 32'hAAAA5555, 2'b01}, NEVER, 1,
                40'h12_3456_789A, 0, 0, 10, {6'h10, 32'h0, 2'b10}, 2'd2};
    vecs[4] = '{"timeout_in_done", {6'h22, 32'h0BADF00D, 2'b10}, 2, 20,
                40'h55_5555_5555, 0, 0, 10, {6'h22, 32'h0, 2'b10}, 2'd2};
    vecs[5] = '{"reset_beats_ovr", {6'h05, 32'h1, 2'b01}, 1, 1,
                {6'h05, 32'h77, 2'b00}, 2, 2, 4, {6'h05, 32'h77, 2'b00}, 2'd0};
    vecs[6] = '{"reset_after_ovr", {6'h06, 32'h2, 2'b01}, 1, 2,
                {6'h06, 32'h88, 2'b00}, 2, 3, 5, {6'h06, 32'h88, 2'b00}, 2'd0};
    vecs[7] = '{"latest_in_time", {6'h07, 32'h3, 2'b01}, 3, 4,
                {6'h07, 32'h99, 2'b00}, 0, 0, 9, {6'h07, 32'h99, 2'b00}, 2'd0};
    vecs[8] = '{"timeout_then_ovr", {6'h08, 32'h4, 2'b01}, NEVER, 1,
                40'h0, 10, 0, 10, {6'h08, 32'h0, 2'b10}, 2'd2};
    vecs[9] = '{"ovr_then_timeout", {6'h09, 32'h5, 2'b10}, NEVER, 1,
                40'h0, 3, 0, 10, {6'h09, 32'h0, 2'b10}, 2'd3};

    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = '0;
    dmi_reset    = 1'b0;
    dm_is_busy   = 1'b0;
    dm_resp_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset cmd_ready", cmd_ready, 1);
    check("reset dtm_req_valid", dtm_req_valid, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset dmi_busy", dmi_busy, 0);
    check("reset dmi_stat", dmi_stat, 0);
    check("reset dtm_req_data", dtm_req_data, 0);
    check("reset rsp_data", rsp_data, 0);

    // Table of directed transactions.
    foreach (vecs[i]) begin
      run_txn(vecs[i].name, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].resp,
              vecs[i].ovr_at, vecs[i].dr_at, vecs[i].exp_rc, vecs[i].exp_rsp,
              vecs[i].exp_stat);
      if (vecs[i].exp_stat != 2'd0) pulse_dmi_reset(vecs[i].name);
    end

    // Overrun: one request only, later command dropped until dmi_reset.
    run_txn("overrun", {6'h11, 32'h0, 2'b01}, 1, 1, {6'h11, 32'h400982, 2'b00},
            2, 0, 4, {6'h11, 32'h400982, 2'b00}, 2'd3);
    drop_cmd("overrun", {6'h04, 32'h1234, 2'b10}, 2'd3);
    pulse_dmi_reset("overrun");
    run_txn("after_dmi_reset", {6'h04, 32'h1234, 2'b10}, 1, 1, {6'h04, 32'h0, 2'b00},
            0, 0, 4, {6'h04, 32'h0, 2'b00}, 2'd0);

    // rst in WAIT_DONE, then the DM response arrives.
    begin
      bit rsp_seen = 0, outs_ok = 1;
      cmd_valid    = 1'b1;
      cmd_data     = {6'h12, 32'hFEEDFACE, 2'b01};
      dm_resp_data = 40'hAB_CDEF_0123;
      for (int n = 1; n <= 9; n++) begin
        @(negedge clk);
        cmd_valid  = 1'b0;
        rst        = (n == 4) || (n == 5);
        dm_is_busy = (n >= 2) && (n < 6);
        if (n == 4) check("rst_mid waiting", dmi_busy, 1);
        if (n >= 5) begin
          if (rsp_valid) rsp_seen = 1;
          if (dtm_req_valid !== 1'b0 || dmi_busy !== 1'b0 || dmi_stat !== 2'd0 ||
              dtm_req_data !== 40'h0 || rsp_data !== 40'h0 || cmd_ready !== 1'b1)
            outs_ok = 0;
        end
      end
      check("rst_mid no_rsp_valid", rsp_seen, 0);
      check("rst_mid outputs_at_reset", outs_ok, 1);
      run_txn("after_rst", {6'h13, 32'h5A5A5A5A, 2'b10}, 1, 1, {6'h13, 32'h0, 2'b00},
              0, 0, 4, {6'h13, 32'h0, 2'b00}, 2'd0);
    end

    // Randomized transactions against the reference model.
    s_model = 2'd0;
    for (int t = 0; t < 30; t++) begin
      cmd  = {6'($urandom), 32'($urandom), 2'($urandom_range(0, 2))};
      resp = {cmd[39:34], 32'($urandom), 2'($urandom_range(0, 3))};
      mode = $urandom_range(0, 5);
      a    = $urandom_range(1, 3);
      if (mode == 0) begin
        a = NEVER;
        b = 1;
      end else if (mode == 1) begin
        b = $urandom_range(TO - a + 1, TO + 6);
      end else begin
        b = $urandom_range(1, TO - 1 - a);
      end
      predict(cmd, a, b, resp, 0, 0, 2'd0, rc, exp_rsp, s_model);
      ovr_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, rc) : 0;
      dr_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rc) : 0;
      predict(cmd, a, b, resp, ovr_at, dr_at, 2'd0, rc, exp_rsp, s_model);
      run_txn("random", cmd, a, b, resp, ovr_at, dr_at, rc, exp_rsp, s_model);
      if (s_model != 2'd0) begin
        if ($urandom_range(0, 1) == 1) drop_cmd("random", ~cmd, s_model);
        pulse_dmi_reset("random");
        s_model = 2'd0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_jtag_dmi_initiator
